// File: rtl/reg_bank_loader_pkg.sv
// Shared types and constants for the register-bank loader.
// The optional checksum stage is enabled with REG_BANK_LOADER_CHECKSUM_EN.
package reg_bank_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CHK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int BYTE_W = 8;
    localparam int CSUM_W = 8;

endpackage

// File: rtl/reg_bank_loader_onehot_decoder.sv
// Gated one-hot decoder: drives bit idx of onehot when en is high, all zeros otherwise.
module reg_bank_loader_onehot_decoder #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [IDX_W-1:0]    idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign onehot[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/reg_bank_loader.sv
// Streams NUM_REGS bytes into a shared-bus register bank with one-hot load enables.
// Define REG_BANK_LOADER_CHECKSUM_EN to append a modulo-256 checksum byte after the data.
module reg_bank_loader
    import reg_bank_loader_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = BYTE_W,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic [DATA_W-1:0]   reg_data,
    output logic [NUM_REGS-1:0] reg_en,
    output logic [IDX_W-1:0]    idx,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [NUM_REGS-1:0] en_reg, en_next;
    logic                ready_reg, ready_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                load_fire;
    logic                handshake;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0]   sum_reg, sum_next;
    logic                err_reg, err_next;
`endif

    assign handshake = in_valid && ready_reg;

    // Enable is decoded from the pre-increment index so byte i lands on register i.
    reg_bank_loader_onehot_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_decoder (
        .idx    (idx_reg),
        .en     (load_fire),
        .onehot (en_next)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        ready_next = ready_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        load_fire  = 1'b0;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
        sum_next   = sum_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    idx_next   = '0;
                    ready_next = 1'b1;
                    busy_next  = 1'b1;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
                    sum_next   = '0;
                    err_next   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    load_fire = 1'b1;
                    data_next = in_data;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
                    sum_next  = sum_reg + CSUM_W'(in_data);
`endif
                    if (idx_reg == IDX_W'(NUM_REGS - 1)) begin
                        idx_next   = '0;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
                        state_next = ST_CHK;
`else
                        ready_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = ST_DONE;
`endif
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
`ifdef REG_BANK_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (handshake) begin
                    err_next   = (CSUM_W'(in_data) != sum_reg);
                    ready_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                ready_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            data_reg  <= '0;
            en_reg    <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
            sum_reg   <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            en_reg    <= en_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
            sum_reg   <= sum_next;
            err_reg   <= err_next;
`endif
        end
    end

    assign in_ready = ready_reg;
    assign reg_data = data_reg;
    assign reg_en   = en_reg;
    assign idx      = idx_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
    assign err      = err_reg;
`else
    assign err      = 1'b0;
`endif

endmodule
